// File: rtl/odo_sbox_bank.sv
// odo_sbox_bank
//   Runtime-loadable, multi-lane S-box for the Odo mixing datapath. A table of
//   DEPTH = 2**W entries is streamed in one beat per entry. While it loads, the
//   block records which values have been seen. Lookups are enabled only when the
//   completed table is a permutation. LANES independent lookups share one table
//   and return their results one cycle after they are accepted.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   ld_start  pulse: begin (or restart) a table load
//   ld_valid  load beat valid
//   ld_data   table entry for the current load address
//   ld_ready  load beat accepted when ld_valid & ld_ready
//   in_valid  lookup request valid
//   in_data   lane k index = in_data[k*W +: W]
//   in_ready  lookup accepted when in_valid & in_ready
//   out_valid lookup result valid (one cycle after accept)
//   out_data  lane k result = table[lane k index]; holds when out_valid=0
//   table_ok  table loaded and verified as a permutation
//   perm_err  last completed load contained a duplicate value

module odo_sbox_bank #(
    parameter int W     = 6,
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ld_start,
    input  logic               ld_valid,
    input  logic [W-1:0]       ld_data,
    output logic               ld_ready,
    input  logic               in_valid,
    input  logic [LANES*W-1:0] in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [LANES*W-1:0] out_data,
    output logic               table_ok,
    output logic               perm_err
);

    localparam int DEPTH = 1 << W;

    typedef enum logic [1:0] {
        EMPTY,
        LOAD,
        READY,
        ERROR
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [W-1:0]     cnt;
    logic [DEPTH-1:0] seen;
    logic             dup;
    logic [W-1:0]     mem [DEPTH];

    logic             ld_acc;
    logic             lk_acc;
    logic             beat_dup;
    logic             last_beat;

    assign ld_acc    = ld_valid & ld_ready;
    assign lk_acc    = in_valid & in_ready;
    // The seen bit is read before this beat updates it. That read catches a
    // duplicate on the final beat, which dup cannot yet include.
    assign beat_dup  = seen[ld_data];
    assign last_beat = ld_acc && (cnt == W'(DEPTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. ld_start wins from every state, including LOAD,
    // where it restarts the load from address 0.
    always_comb begin
        state_nxt = state;
        if (ld_start) begin
            state_nxt = LOAD;
        end else begin
            case (state)
                LOAD: begin
                    if (last_beat) begin
                        state_nxt = (dup | beat_dup) ? ERROR : READY;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Output decode. ld_start blocks both handshakes in its own cycle. No
    // lookup can then race a restart, and a beat presented alongside the
    // restart is not accepted.
    always_comb begin
        ld_ready = 1'b0;
        in_ready = 1'b0;
        table_ok = 1'b0;
        perm_err = 1'b0;
        case (state)
            LOAD:    ld_ready = ~ld_start;
            READY: begin
                in_ready = ~ld_start;
                table_ok = 1'b1;
            end
            ERROR:   perm_err = 1'b1;
            default: ;
        endcase
    end

    // Load bookkeeping: the address counter, the bitmap of values already
    // written, and a sticky flag that records any duplicate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            seen <= '0;
            dup  <= 1'b0;
        end else if (ld_start) begin
            cnt  <= '0;
            seen <= '0;
            dup  <= 1'b0;
        end else if (ld_acc) begin
            cnt           <= cnt + 1'b1;
            seen[ld_data] <= 1'b1;
            dup           <= dup | beat_dup;
        end
    end

    // Table storage has no reset. State gating prevents reads of stale
    // contents until a full load has been verified.
    always_ff @(posedge clk) begin
        if (ld_acc) begin
            mem[cnt] <= ld_data;
        end
    end

    // Registered lookup for all lanes. out_data holds its value between
    // results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= lk_acc;
            if (lk_acc) begin
                for (int k = 0; k < LANES; k++) begin
                    out_data[k*W +: W] <= mem[in_data[k*W +: W]];
                end
            end
        end
    end

endmodule

// File: tb/tb_odo_sbox_bank.sv
// tb_odo_sbox_bank
//   Directed bench for odo_sbox_bank (W=6, LANES=4). The stimulus side pushes
//   each expected lookup result, with the cycle in which it must appear, into a
//   queue. A monitor on the falling edge pops and compares whenever out_valid
//   is seen. The monitor also checks that out_data holds between results.

module tb_odo_sbox_bank;

    localparam int W     = 6;
    localparam int LANES = 4;
    localparam int DEPTH = 64;

    typedef struct packed {
        logic [LANES*W-1:0] data;
        int                 cyc;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               ld_start;
    logic               ld_valid;
    logic [W-1:0]       ld_data;
    logic               ld_ready;
    logic               in_valid;
    logic [LANES*W-1:0] in_data;
    logic               in_ready;
    logic               out_valid;
    logic [LANES*W-1:0] out_data;
    logic               table_ok;
    logic               perm_err;

    exp_t               exp_q[$];
    logic [W-1:0]       ref_mem [DEPTH];
    int                 vectors     = 0;
    int                 miscompares = 0;
    int                 cycle       = 0;
    logic [LANES*W-1:0] last_out    = '0;
    logic               prev_rst    = 1'b0;

    odo_sbox_bank #(.W(W), .LANES(LANES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_start  (ld_start),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .table_ok  (table_ok),
        .perm_err  (perm_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cycle);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LANES*W-1:0] pack4(input int a, input int b, input int c, input int d);
        return {6'(d), 6'(c), 6'(b), 6'(a)};
    endfunction

    // Table patterns: 0 = (5i+3)%64, 1 = 63-i with entry 5 forced to 0,
    // 2 = 63-i, 3 = (7i+1)%64
    function automatic logic [W-1:0] gen_val(input int kind, input int i);
        case (kind)
            0:       return 6'((5 * i + 3) % 64);
            1:       return (i == 5) ? 6'd0 : 6'(63 - i);
            2:       return 6'(63 - i);
            default: return 6'((7 * i + 1) % 64);
        endcase
    endfunction

    function automatic logic [LANES*W-1:0] model_lookup(input logic [LANES*W-1:0] idx);
        logic [LANES*W-1:0] r;
        for (int k = 0; k < LANES; k++) begin
            r[k*W +: W] = ref_mem[idx[k*W +: W]];
        end
        return r;
    endfunction

    task automatic start_load(input logic beat_too);
        ld_start = 1'b1;
        ld_valid = beat_too;
        ld_data  = 6'h15;
        in_valid = 1'b0;
        #1;
        check_output("in_ready during ld_start", 32'(in_ready), 32'd0);
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b0;
        #1;
        check_output("ld_ready in LOAD", 32'(ld_ready), 32'd1);
    endtask

    task automatic load_beats(input int kind, input int first, input int last, input logic gaps);
        for (int i = first; i <= last; i++) begin
            if (gaps && (i % 7 == 3)) begin
                ld_valid = 1'b0;
                tick();
            end
            ld_valid   = 1'b1;
            ld_data    = gen_val(kind, i);
            ref_mem[i] = gen_val(kind, i);
            tick();
        end
        ld_valid = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [LANES*W-1:0] idx, input logic [LANES*W-1:0] expd);
        exp_t e;
        in_valid = 1'b1;
        in_data  = idx;
        #1;
        check_output("in_ready in READY", 32'(in_ready), 32'd1);
        e.data = expd;
        e.cyc  = cycle + 1;
        exp_q.push_back(e);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic blocked_lookups(input string name, input int n);
        in_valid = 1'b1;
        in_data  = pack4(1, 2, 3, 4);
        for (int i = 0; i < n; i++) begin
            #1;
            check_output(name, 32'(in_ready), 32'd0);
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cycle) begin
                e = exp_q.pop_front();
                vectors++;
                miscompares++;
                $display("[TB] FAIL missing result: got no out_valid, expected %0h at cycle %0d", e.data, e.cyc);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected out_valid: got data %0h, expected none (cycle %0d)", out_data, cycle);
                end else begin
                    e = exp_q.pop_front();
                    check_output("lookup data", 32'(out_data), 32'(e.data));
                    check_output("lookup latency", 32'(cycle), 32'(e.cyc));
                end
            end else if (prev_rst) begin
                check_output("out_data hold", 32'(out_data), 32'(last_out));
            end
        end
        last_out = out_data;
        prev_rst = rst_n;
    end

    initial begin
        rst_n    = 1'b0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_data  = '0;
        in_valid = 1'b0;
        in_data  = '0;

        // Reset with random inputs
        for (int i = 0; i < 4; i++) begin
            ld_start = 1'($urandom);
            ld_valid = 1'($urandom);
            ld_data  = 6'($urandom);
            in_valid = 1'($urandom);
            in_data  = 24'($urandom);
            @(negedge clk);
            check_output("reset outputs", {27'd0, ld_ready, in_ready, out_valid, table_ok, perm_err}, 32'd0);
            check_output("reset out_data", 32'(out_data), 32'd0);
        end
        ld_start = 1'b0;
        ld_valid = 1'b0;
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        blocked_lookups("in_ready in EMPTY", 3);
        check_output("table_ok in EMPTY", 32'(table_ok), 32'd0);

        // Load (5i+3)%64 and look up
        start_load(1'b0);
        load_beats(0, 0, 62, 1'b1);
        check_output("table_ok before last beat", 32'(table_ok), 32'd0);
        load_beats(0, 63, 63, 1'b0);
        check_output("table_ok after last beat", 32'(table_ok), 32'd1);
        check_output("perm_err after good load", 32'(perm_err), 32'd0);
        check_output("ld_ready after load", 32'(ld_ready), 32'd0);
        apply_stimulus(pack4(0, 10, 63, 1), pack4(3, 53, 62, 8));
        apply_stimulus(pack4(7, 7, 7, 7), pack4(38, 38, 38, 38));
        tick();
        tick();

        // Random lookups with gaps
        for (int i = 0; i < 100; i++) begin
            logic [LANES*W-1:0] idx;
            idx = 24'($urandom);
            if ($urandom_range(0, 2) != 0) begin
                apply_stimulus(idx, model_lookup(idx));
            end else begin
                in_valid = 1'b0;
                in_data  = idx;
                tick();
            end
        end
        tick();

        // Duplicate in load, then recovery
        start_load(1'b0);
        load_beats(1, 0, 63, 1'b1);
        check_output("perm_err after dup load", 32'(perm_err), 32'd1);
        check_output("table_ok after dup load", 32'(table_ok), 32'd0);
        check_output("ld_ready in ERROR", 32'(ld_ready), 32'd0);
        blocked_lookups("in_ready in ERROR", 3);
        start_load(1'b0);
        check_output("perm_err cleared by ld_start", 32'(perm_err), 32'd0);
        load_beats(0, 0, 63, 1'b0);
        check_output("perm_err after reload", 32'(perm_err), 32'd0);
        check_output("table_ok after reload", 32'(table_ok), 32'd1);
        apply_stimulus(pack4(0, 10, 63, 1), pack4(3, 53, 62, 8));

        // Lookup just before ld_start uses the old table; restart mid-load
        apply_stimulus(pack4(1, 2, 3, 4), pack4(8, 13, 18, 23));
        start_load(1'b1);
        load_beats(2, 0, 19, 1'b0);
        start_load(1'b1);
        load_beats(3, 0, 43, 1'b0);
        check_output("table_ok after 64 total beats", 32'(table_ok), 32'd0);
        load_beats(3, 44, 62, 1'b1);
        check_output("table_ok before restarted last beat", 32'(table_ok), 32'd0);
        load_beats(3, 63, 63, 1'b0);
        check_output("table_ok after restarted load", 32'(table_ok), 32'd1);
        for (int j = 0; j < 5; j++) begin
            logic [LANES*W-1:0] idx;
            idx = pack4(4 * j, 4 * j + 1, 4 * j + 2, 4 * j + 3);
            apply_stimulus(idx, model_lookup(idx));
        end
        tick();

        // Reset mid-LOAD
        start_load(1'b0);
        load_beats(0, 0, 29, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check_output("ld_ready async reset", 32'(ld_ready), 32'd0);
        check_output("table_ok async reset in LOAD", 32'(table_ok), 32'd0);
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        blocked_lookups("in_ready after reset mid-load", 3);

        // Reset in READY while a result is out
        start_load(1'b0);
        load_beats(0, 0, 63, 1'b1);
        check_output("table_ok before READY reset", 32'(table_ok), 32'd1);
        apply_stimulus(pack4(2, 3, 4, 5), pack4(13, 18, 23, 28));
        check_output("out_valid before reset", 32'(out_valid), 32'd1);
        in_valid = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check_output("out_valid async reset", 32'(out_valid), 32'd0);
        check_output("out_data async reset", 32'(out_data), 32'd0);
        check_output("table_ok async reset", 32'(table_ok), 32'd0);
        check_output("in_ready async reset", 32'(in_ready), 32'd0);
        exp_q.delete();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        blocked_lookups("in_ready after reset in READY", 2);
        start_load(1'b0);
        load_beats(2, 0, 63, 1'b0);
        check_output("table_ok after final reload", 32'(table_ok), 32'd1);
        apply_stimulus(pack4(0, 63, 32, 5), pack4(63, 0, 31, 58));

        repeat (3) tick();
        check_output("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
